midi_voice_alloc: RTL

//  Polyphonic voice allocator/scheduler between the MIDI byte parser and the NUM_VOICES oscillator/envelope voices.

---
 rtl/midi_voice_alloc.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: assigns decoded MIDI note events to NUM_VOICES voices.
// Optional sustain pedal (CC64) support is compiled in when SUSTAIN_PEDAL_EN is defined.
module midi_voice_alloc #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ev_valid,
    output logic                              ev_ready,
    input  logic [1:0]                        ev_type,
    input  logic [6:0]                        ev_note,
    input  logic [6:0]                        ev_value,
    input  logic [NUM_VOICES-1:0]             voice_idle,
    output logic [NUM_VOICES-1:0]             voice_gate,
    output logic [NUM_VOICES-1:0]             voice_trig,
    output logic [NUM_VOICES*7-1:0]           voice_note,
    output logic [NUM_VOICES*7-1:0]           voice_vel,
    output logic                              steal_pulse,
    output logic [$clog2(NUM_VOICES+1)-1:0]   active_count
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES+1);

    typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;

    state_t state, next_state;

    logic [1:0]            type_q;
    logic [6:0]            note_q;
    logic [6:0]            value_q;
    logic [AGE_W-1:0]      age [NUM_VOICES];

    logic [NUM_VOICES-1:0] match;
    logic [IDX_W-1:0]      retrig_idx;
    logic [IDX_W-1:0]      idle_idx;
    logic [IDX_W-1:0]      rel_idx;
    logic [IDX_W-1:0]      old_idx;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  idle_found;
    logic                  rel_found;
    logic                  do_steal;
    logic                  is_on;
    logic                  is_off;

`ifdef SUSTAIN_PEDAL_EN
    logic                  pedal_down;
    logic [NUM_VOICES-1:0] sustained;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        ev_ready   = 1'b0;
        case (state)
            IDLE: begin
                ev_ready = !rst;
                if (ev_valid && !rst) next_state = SEARCH;
            end
            SEARCH:  next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign is_on  = (type_q == 2'd1) && (value_q != 7'd0);
    assign is_off = (type_q == 2'd0) || ((type_q == 2'd1) && (value_q == 7'd0));

    // Candidate search: first idle voice, oldest released voice, oldest gated voice.
    always_comb begin
        match      = '0;
        retrig_idx = '0;
        idle_found = 1'b0;
        idle_idx   = '0;
        rel_found  = 1'b0;
        rel_idx    = '0;
        old_idx    = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            match[i] = voice_gate[i] && (voice_note[i*7 +: 7] == note_q);
            if (!idle_found && !voice_gate[i] && voice_idle[i]) begin
                idle_found = 1'b1;
                idle_idx   = IDX_W'(i);
            end
            if (!voice_gate[i] && (!rel_found || age[i] > age[rel_idx])) begin
                rel_found = 1'b1;
                rel_idx   = IDX_W'(i);
            end
            if (voice_gate[i] && age[i] > age[old_idx]) old_idx = IDX_W'(i);
        end
        for (int i = NUM_VOICES-1; i >= 0; i--) begin
            if (match[i]) retrig_idx = IDX_W'(i);
        end
        alloc_idx = idle_found ? idle_idx : (rel_found ? rel_idx : old_idx);
        do_steal  = !idle_found && !rel_found;
    end

    // Voice state is written at the end of SEARCH so it is visible during COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            type_q      <= '0;
            note_q      <= '0;
            value_q     <= '0;
            voice_gate  <= '0;
            voice_trig  <= '0;
            voice_note  <= '0;
            voice_vel   <= '0;
            steal_pulse <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
`ifdef SUSTAIN_PEDAL_EN
            pedal_down  <= 1'b0;
            sustained   <= '0;
`endif
        end else begin
            voice_trig  <= '0;
            steal_pulse <= 1'b0;
            if (state == IDLE && ev_valid) begin
                type_q  <= ev_type;
                note_q  <= ev_note;
                value_q <= ev_value;
            end
            if (state == SEARCH) begin
                if (is_on && (|match)) begin
                    voice_trig[retrig_idx]            <= 1'b1;
                    voice_vel[retrig_idx*7 +: 7]      <= value_q;
                    age[retrig_idx]                   <= '0;
`ifdef SUSTAIN_PEDAL_EN
                    sustained[retrig_idx]             <= 1'b0;
`endif
                end else if (is_on) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) != alloc_idx && age[i] != '1) age[i] <= age[i] + 1'b1;
                    end
                    age[alloc_idx]               <= '0;
                    voice_gate[alloc_idx]        <= 1'b1;
                    voice_trig[alloc_idx]        <= 1'b1;
                    voice_note[alloc_idx*7 +: 7] <= note_q;
                    voice_vel[alloc_idx*7 +: 7]  <= value_q;
                    steal_pulse                  <= do_steal;
`ifdef SUSTAIN_PEDAL_EN
                    sustained[alloc_idx]         <= 1'b0;
`endif
                end else if (is_off) begin
`ifdef SUSTAIN_PEDAL_EN
                    if (pedal_down) sustained  <= sustained | match;
                    else            voice_gate <= voice_gate & ~match;
`else
                    voice_gate <= voice_gate & ~match;
`endif
                end else if (type_q == 2'd3) begin
                    voice_gate <= '0;
`ifdef SUSTAIN_PEDAL_EN
                    sustained  <= '0;
`endif
                end
`ifdef SUSTAIN_PEDAL_EN
                else if (type_q == 2'd2 && note_q == 7'd64) begin
                    if (value_q[6]) begin
                        pedal_down <= 1'b1;
                    end else begin
                        pedal_down <= 1'b0;
                        voice_gate <= voice_gate & ~sustained;
                        sustained  <= '0;
                    end
                end
`endif
            end
        end
    end

    always_comb begin
        active_count = '0;
        for (int i = 0; i < NUM_VOICES; i++) active_count = active_count + CNT_W'(voice_gate[i]);
    end

endmodule
